// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters,
// E-stage mispredict detection/redirect, and saturating branch/mispredict statistics.
module branch_predictor #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CTR_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  // fetch-stage lookup
  input  logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  // execute-stage resolution
  input  logic            UpdateE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic            TakenE,
  input  logic [XLEN-1:0] TargetE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  output logic            MispredictE,
  output logic [XLEN-1:0] RedirectPCE,
  input  logic            Clear,
  output logic [31:0]     BranchCount,
  output logic [31:0]     MispredCount
);

  localparam int unsigned IW = $clog2(ENTRIES);
  localparam int unsigned TW = XLEN - IW - 2;

  localparam logic [CTR_BITS-1:0] CtrMax  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CtrWkT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CtrWkNt = CtrWkT - CTR_BITS'(1);

  logic                valid_q  [ENTRIES];
  logic [TW-1:0]       tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  logic [31:0] branch_count_q;
  logic [31:0] mispred_count_q;

  // ---------------------------------------------------------------------------
  // Fetch-stage lookup
  // ---------------------------------------------------------------------------
  logic [IW-1:0] f_idx;
  logic [TW-1:0] f_tag;
  logic          f_hit;

  always_comb begin
    f_idx       = PCF[IW+1:2];
    f_tag       = PCF[XLEN-1:IW+2];
    f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag) && !reset;
    PredTakenF  = f_hit && ctr_q[f_idx][CTR_BITS-1];
    PredTargetF = f_hit ? target_q[f_idx] : PCF + XLEN'(4);
  end

  // ---------------------------------------------------------------------------
  // Execute-stage resolution
  // ---------------------------------------------------------------------------
  logic [IW-1:0] e_idx;
  logic [TW-1:0] e_tag;
  logic          e_hit;

  always_comb begin
    e_idx       = PCE[IW+1:2];
    e_tag       = PCE[XLEN-1:IW+2];
    e_hit       = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    MispredictE = UpdateE &&
                  ((TakenE != PredTakenE) ||
                   (TakenE && PredTakenE && (TargetE != PredTargetE)));
    RedirectPCE = TakenE ? TargetE : PCPlus4E;
  end

  // ---------------------------------------------------------------------------
  // Table update; Clear wins over a coincident update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CtrWkNt;
      end
    end else if (Clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (UpdateE) begin
      if (e_hit) begin
        if (TakenE) begin
          target_q[e_idx] <= TargetE;
          if (ctr_q[e_idx] != CtrMax) begin
            ctr_q[e_idx] <= ctr_q[e_idx] + CTR_BITS'(1);
          end
        end else if (ctr_q[e_idx] != '0) begin
          ctr_q[e_idx] <= ctr_q[e_idx] - CTR_BITS'(1);
        end
      end else if (TakenE) begin
        valid_q[e_idx]  <= 1'b1;
        tag_q[e_idx]    <= e_tag;
        target_q[e_idx] <= TargetE;
        ctr_q[e_idx]    <= CtrWkT;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics; independent of Clear
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count_q  <= '0;
      mispred_count_q <= '0;
    end else begin
      if (UpdateE && (branch_count_q != '1)) begin
        branch_count_q <= branch_count_q + 32'd1;
      end
      if (MispredictE && (mispred_count_q != '1)) begin
        mispred_count_q <= mispred_count_q + 32'd1;
      end
    end
  end

  assign BranchCount  = branch_count_q;
  assign MispredCount = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized check of branch_predictor against a table model kept
// in terms of PC arithmetic and integer counters.
module tb_branch_predictor;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ENTRIES  = 16;
  localparam int unsigned CTR_BITS = 2;
  localparam int          CMAX     = (1 << CTR_BITS) - 1;
  localparam int          HALF     = 1 << (CTR_BITS - 1);

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] PCF;
  logic            PredTakenF;
  logic [XLEN-1:0] PredTargetF;
  logic            UpdateE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic            TakenE;
  logic [XLEN-1:0] TargetE;
  logic            PredTakenE;
  logic [XLEN-1:0] PredTargetE;
  logic            MispredictE;
  logic [XLEN-1:0] RedirectPCE;
  logic            Clear;
  logic [31:0]     BranchCount;
  logic [31:0]     MispredCount;

  branch_predictor #(
    .XLEN    (XLEN),
    .ENTRIES (ENTRIES),
    .CTR_BITS(CTR_BITS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .PCF         (PCF),
    .PredTakenF  (PredTakenF),
    .PredTargetF (PredTargetF),
    .UpdateE     (UpdateE),
    .PCE         (PCE),
    .PCPlus4E    (PCPlus4E),
    .TakenE      (TakenE),
    .TargetE     (TargetE),
    .PredTakenE  (PredTakenE),
    .PredTargetE (PredTargetE),
    .MispredictE (MispredictE),
    .RedirectPCE (RedirectPCE),
    .Clear       (Clear),
    .BranchCount (BranchCount),
    .MispredCount(MispredCount)
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // reference model: one record per table slot, addressed by PC arithmetic
  bit              m_valid [ENTRIES];
  longint unsigned m_tag   [ENTRIES];
  logic [XLEN-1:0] m_tgt   [ENTRIES];
  int              m_ctr   [ENTRIES];
  longint unsigned m_bc, m_mc;

  function automatic int slot(input logic [XLEN-1:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic longint unsigned tag_of(input logic [XLEN-1:0] pc);
    return longint'(pc) / (4 * ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [XLEN-1:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred_taken(input logic [XLEN-1:0] pc);
    return m_hit(pc) && (m_ctr[slot(pc)] >= HALF);
  endfunction

  function automatic logic [XLEN-1:0] m_pred_target(input logic [XLEN-1:0] pc);
    return m_hit(pc) ? m_tgt[slot(pc)] : pc + 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_tgt[i]   = '0;
      m_ctr[i]   = HALF - 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, then apply the
  // model update at the rising edge.
  task automatic step(input bit clr, input bit upd, input logic [XLEN-1:0] pcf,
                      input logic [XLEN-1:0] pce, input bit tk, input logic [XLEN-1:0] tgt,
                      input bit ptk, input logic [XLEN-1:0] ptgt);
    bit emis;
    int s;
    @(negedge clk);
    Clear = clr; UpdateE = upd; PCF = pcf; PCE = pce; PCPlus4E = pce + 4;
    TakenE = tk; TargetE = tgt; PredTakenE = ptk; PredTargetE = ptgt;
    #1;
    emis = upd && ((tk != ptk) || (tk && ptk && (tgt != ptgt)));
    chk("PredTakenF", 64'(PredTakenF), 64'(m_pred_taken(pcf)));
    chk("PredTargetF", 64'(PredTargetF), 64'(m_pred_target(pcf)));
    chk("MispredictE", 64'(MispredictE), 64'(emis));
    if (emis) chk("RedirectPCE", 64'(RedirectPCE), 64'(tk ? tgt : pce + 4));
    chk("BranchCount", 64'(BranchCount), 64'(m_bc));
    chk("MispredCount", 64'(MispredCount), 64'(m_mc));
    @(posedge clk);
    if (upd) m_bc++;
    if (emis) m_mc++;
    s = slot(pce);
    if (clr) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
    end else if (upd) begin
      if (m_hit(pce)) begin
        if (tk) begin
          m_tgt[s] = tgt;
          if (m_ctr[s] < CMAX) m_ctr[s]++;
        end else if (m_ctr[s] > 0) begin
          m_ctr[s]--;
        end
      end else if (tk) begin
        m_valid[s] = 1;
        m_tag[s]   = tag_of(pce);
        m_tgt[s]   = tgt;
        m_ctr[s]   = HALF;
      end
    end
  endtask

  // update a branch using the prediction the fetch stage would have made
  task automatic br(input logic [XLEN-1:0] pc, input bit tk, input logic [XLEN-1:0] tgt);
    step(0, 1, pc, pc, tk, tgt, m_pred_taken(pc), m_pred_target(pc));
  endtask

  task automatic idle(input logic [XLEN-1:0] pcf);
    step(0, 0, pcf, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    logic [XLEN-1:0] pc, tgt;
    bit              tk, ptk;
    logic [XLEN-1:0] ptgt;

    // reset state
    reset = 1'b1; Clear = 0; UpdateE = 0; PCF = 32'h100; PCE = 0; PCPlus4E = 4;
    TakenE = 0; TargetE = 0; PredTakenE = 0; PredTargetE = 0;
    model_reset();
    #3;
    chk("rst_PredTakenF", 64'(PredTakenF), 64'd0);
    chk("rst_PredTargetF", 64'(PredTargetF), 64'h104);
    chk("rst_BranchCount", 64'(BranchCount), 64'd0);
    chk("rst_MispredCount", 64'(MispredCount), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // first taken branch allocates weakly taken
    step(0, 1, 32'h100, 32'h100, 1, 32'h80, 0, 32'h0);
    idle(32'h100);
    chk("alloc_taken", 64'(PredTakenF), 64'd1);
    chk("alloc_target", 64'(PredTargetF), 64'h80);

    // counter walks down and saturates, then back up
    br(32'h100, 0, 32'h0);
    idle(32'h100);
    chk("nt1_PredTakenF", 64'(PredTakenF), 64'd0);
    br(32'h100, 0, 32'h0);
    br(32'h100, 0, 32'h0);
    br(32'h100, 1, 32'h80);
    idle(32'h100);
    chk("t1_PredTakenF", 64'(PredTakenF), 64'd0);
    br(32'h100, 1, 32'h80);
    idle(32'h100);
    chk("t2_PredTakenF", 64'(PredTakenF), 64'd1);

    // aliasing: 0x140 shares index with 0x100 and evicts it
    br(32'h140, 1, 32'hA0);
    idle(32'h100);
    chk("alias_evicted", 64'(PredTakenF), 64'd0);
    idle(32'h140);

    // right direction, wrong target
    br(32'h100, 1, 32'h80);
    step(0, 1, 32'h100, 32'h100, 1, 32'h90, 1, 32'h80);
    idle(32'h100);
    chk("retarget", 64'(PredTargetF), 64'h90);

    // Clear beats a coincident update
    br(32'h200, 1, 32'h300);
    step(1, 1, 32'h200, 32'h240, 1, 32'h400, 0, 32'h0);
    idle(32'h200);
    idle(32'h240);
    idle(32'h100);

    // asynchronous reset mid-cycle, with an update pending across the edge
    br(32'h200, 1, 32'h300);
    @(negedge clk);
    PCF = 32'h200; UpdateE = 1; PCE = 32'h240; TakenE = 1; TargetE = 32'h400;
    PredTakenE = 0; Clear = 0;
    #2 reset = 1'b1;
    #1;
    chk("async_BranchCount", 64'(BranchCount), 64'd0);
    chk("async_MispredCount", 64'(MispredCount), 64'd0);
    chk("async_PredTakenF", 64'(PredTakenF), 64'd0);
    chk("async_PredTargetF", 64'(PredTargetF), 64'h204);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    UpdateE = 0;
    idle(32'h240);
    idle(32'h200);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      pc  = XLEN'($urandom_range(0, 127) * 4);
      tgt = XLEN'($urandom_range(0, 255) * 4);
      tk  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) != 0) begin
        ptk  = m_pred_taken(pc);
        ptgt = m_pred_target(pc);
      end else begin
        ptk  = $urandom_range(0, 1) != 0;
        ptgt = XLEN'($urandom_range(0, 255) * 4);
      end
      step($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0,
           XLEN'($urandom_range(0, 127) * 4), pc, tk, tgt, ptk, ptgt);
    end
    idle(32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter XLEN, default 32, datapath/PC width.
REQ-002 Parameter ENTRIES, default 16, table depth; power of two, >=2; IW = log2(ENTRIES).
REQ-003 Parameter CTR_BITS, default 2, saturating-counter width, 1..4.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 PCF  input  XLEN  fetch-stage PC to predict.
REQ-007 PredTakenF  output  1  prediction for PCF, combinational.
REQ-008 PredTargetF  output  XLEN  predicted target for PCF, combinational.
REQ-009 UpdateE  input  1  execute-stage instruction is a valid branch/jal/jalr; low for bubbles/flushed slots.
REQ-010 PCE, PCPlus4E  input  XLEN  execute-stage PC and PC+4.
REQ-011 TakenE  input  1  resolved direction (1 for jal/jalr).
REQ-012 TargetE  input  XLEN  resolved target (PCTarget or jalr ALU result).
REQ-013 PredTakenE, PredTargetE  input  1/XLEN  prediction made for this instruction, carried down the pipeline.
REQ-014 MispredictE  output  1  redirect required, combinational.
REQ-015 RedirectPCE  output  XLEN  correct next PC, combinational.
REQ-016 Clear  input  1  synchronous invalidate of all entries.
REQ-017 BranchCount, MispredCount  output  32  statistics counters.

Function
REQ-018 Index = PC[IW+1:2]; tag = PC[XLEN-1:IW+2]; entry = {valid, tag, target, ctr}.
REQ-019 PredTakenF = valid & tag match & ctr[CTR_BITS-1]; PredTargetF = entry target on hit, else PCF+4.
REQ-020 MispredictE = UpdateE & ((TakenE != PredTakenE) | (TakenE & PredTakenE & TargetE != PredTargetE)).
REQ-021 RedirectPCE = TakenE ? TargetE : PCPlus4E; value is don't-care when MispredictE=0.
REQ-022 Update on hit (UpdateE, tag match): ctr += 1 if TakenE, saturating at 2^CTR_BITS-1; ctr -= 1 if not, saturating at 0; target <= TargetE only when TakenE.
REQ-023 Update on miss with TakenE=1: allocate (overwrite) indexed entry: valid=1, tag, target=TargetE, ctr = 2^(CTR_BITS-1) (weakly taken).
REQ-024 Update on miss with TakenE=0: no table change.
REQ-025 Writes become visible to PCF lookups the cycle after the edge; same-cycle read of the written index returns pre-update contents.
REQ-026 Clear clears all valid bits at the edge; counters and targets unchanged; Clear has priority over a simultaneous update (update dropped).
REQ-027 BranchCount += 1 per cycle with UpdateE; MispredCount += 1 per cycle with MispredictE; both saturate at 2^32-1 and are not affected by Clear.
REQ-028 No internal stall: block always accepts an update; caller holds UpdateE low during E-stage stall cycles to avoid double counting.

Reset
REQ-029 On reset assertion, immediately: all valid=0, all ctr = 2^(CTR_BITS-1)-1 (weakly not-taken), targets/tags 0, both statistics counters 0.
REQ-030 During reset PredTakenF=0, PredTargetF=PCF+4; MispredictE/RedirectPCE remain combinational from inputs.
REQ-031 Reset asserted mid-update discards that update; first update after deassertion applies normally.

Verification
REQ-032 After reset, PCF=0x100 -> PredTakenF=0, PredTargetF=0x104; BranchCount=MispredCount=0.
REQ-033 Update PCE=0x100, TakenE=1, TargetE=0x80, PredTakenE=0 -> MispredictE=1, RedirectPCE=0x80; next cycle PCF=0x100 -> PredTakenF=1, PredTargetF=0x80; counts 1/1.
REQ-034 Same branch: three not-taken updates -> ctr 2->1->0->0 (saturate), PredTakenF=0 after first; then two taken updates -> predicted taken again after second.
REQ-035 Aliasing: PCE=0x100 then 0x140 (ENTRIES=16, same index, different tag), both taken -> second overwrites; PCF=0x100 now misses (PredTakenF=0).
REQ-036 Correct direction wrong target: PredTakenE=1, PredTargetE=0x80, TakenE=1, TargetE=0x90 -> MispredictE=1, RedirectPCE=0x90; entry target becomes 0x90.
REQ-037 Clear and UpdateE same cycle -> all lookups miss next cycle, update not installed; reset asserted asynchronously mid-cycle -> table and counters cleared without waiting for clk.
